boot_prog_ram: RTL and testbench

// - Parametrised single-port program/data RAM for the mproc system, with a built-in boot loader.
// - After reset, the loader accepts a word stream (valid/ready) and writes it from address 0 upward.
// - The processor is held stalled (cpu_hold) until loading completes; the CPU port then owns the RAM.
// - Replaces hard-coded initial-block programs; the top level drives ld_* from a testbench or host.

---
 rtl/mproc_mem_pkg.sv | 18 +
 rtl/boot_prog_ram_if.sv | 28 ++
 rtl/ram_sp.sv | 46 ++++
 rtl/boot_prog_ram.sv | 135 +++++++++++++
 tb/tb_boot_prog_ram.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mproc_mem_pkg.sv
// Shared constants and loader state encoding for the mproc boot/program RAM.
package mproc_mem_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } ld_state_e;

    // True when an accepted word at this count fills the last RAM location.
    function automatic logic is_final_slot(input logic [15:0] count, input int addr_w);
        return (count == 16'((1 << addr_w) - 1));
    endfunction

endpackage

// File: rtl/boot_prog_ram_if.sv
// Loader stream and CPU memory port bundled for the boot/program RAM.
interface boot_prog_ram_if #(
    parameter int ADDR_W = mproc_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = mproc_mem_pkg::DEF_DATA_W
);
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic              ld_ovf;
    logic              cpu_hold;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, cpu_addr, cpu_wr, cpu_din,
        input  ld_ready, ld_count, ld_ovf, cpu_hold, cpu_dout
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, cpu_addr, cpu_wr, cpu_din,
        output ld_ready, ld_count, ld_ovf, cpu_hold, cpu_dout
    );
endinterface

// File: rtl/ram_sp.sv
// Storage array with one write port and one read port; read is combinational
// or registered depending on READ_LAT. Contents are never cleared by reset.
module ram_sp #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Array write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    generate
        if (READ_LAT == 0) begin : g_comb_rd
            logic unused_rst_s;
            assign unused_rst_s = rst_ni;
            assign rdata_o      = mem_r[raddr_i];
        end else begin : g_reg_rd
            logic [DATA_W-1:0] rdata_q;
            // Registered read: a same-address write in this cycle yields the old word.
            always_ff @(posedge clk or negedge rst_ni) begin
                if (!rst_ni) begin
                    rdata_q <= {DATA_W{1'b0}};
                end else begin
                    rdata_q <= mem_r[raddr_i];
                end
            end
            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/boot_prog_ram.sv
// Program/data RAM with boot loader: holds the CPU stalled while a word stream
// is written from address 0, then hands the single port to the CPU.
module boot_prog_ram
    import mproc_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 0
) (
    input  logic           clk,
    input  logic           reset,
    boot_prog_ram_if.slave bus
);
    localparam int             DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    ld_state_e         state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              hold_q;
    logic              ready_q;
    logic              ld_we_s;
    logic              cpu_we_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;

    // Loader FSM: next state, counters and write-port ownership.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ld_we_s  = 1'b0;
        cpu_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ld_start) begin
                    state_d = ST_LOAD;
                    count_d = {(ADDR_W + 1){1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // A restart wins over a word offered in the same cycle.
                if (bus.ld_start) begin
                    count_d = {(ADDR_W + 1){1'b0}};
                    ovf_d   = 1'b0;
                end else if (bus.ld_valid && ready_q) begin
                    ld_we_s = 1'b1;
                    if (count_q != FULL_COUNT) begin
                        count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
                    end else begin
                        count_d = count_q;
                    end
                    if (bus.ld_last) begin
                        state_d = ST_RUN;
                    end else if (is_final_slot(16'(count_q), ADDR_W)) begin
                        ovf_d   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                cpu_we_s = bus.cpu_wr;
                if (bus.ld_start) begin
                    state_d = ST_LOAD;
                    count_d = {(ADDR_W + 1){1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and the decoded handshake outputs, all registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= {(ADDR_W + 1){1'b0}};
            ovf_q   <= 1'b0;
            hold_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            hold_q  <= (state_d != ST_RUN);
            ready_q <= (state_d == ST_LOAD);
        end
    end

    // Write mux: loader and CPU never write in the same state.
    always_comb begin
        ram_we_s    = ld_we_s | cpu_we_s;
        ram_waddr_s = bus.cpu_addr;
        ram_wdata_s = bus.cpu_din;
        if (ld_we_s) begin
            ram_waddr_s = count_q[ADDR_W-1:0];
            ram_wdata_s = bus.ld_data;
        end else begin
            ram_waddr_s = bus.cpu_addr;
            ram_wdata_s = bus.cpu_din;
        end
    end

    ram_sp #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .READ_LAT(READ_LAT)
    ) u_ram (
        .clk    (clk),
        .rst_ni (reset),
        .we_i   (ram_we_s),
        .waddr_i(ram_waddr_s),
        .wdata_i(ram_wdata_s),
        .raddr_i(bus.cpu_addr),
        .rdata_o(bus.cpu_dout)
    );

    assign bus.ld_ready = ready_q;
    assign bus.ld_count = count_q;
    assign bus.ld_ovf   = ovf_q;
    assign bus.cpu_hold = hold_q;

endmodule

// File: tb/tb_boot_prog_ram.sv
// Directed bench: one combinational-read and one registered-read instance driven in lockstep.
module tb_boot_prog_ram;
    localparam int AW = 7;
    localparam int DW = 16;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    boot_prog_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    boot_prog_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    assign bus1.ld_start = bus0.ld_start;
    assign bus1.ld_valid = bus0.ld_valid;
    assign bus1.ld_data  = bus0.ld_data;
    assign bus1.ld_last  = bus0.ld_last;
    assign bus1.cpu_addr = bus0.cpu_addr;
    assign bus1.cpu_wr   = bus0.cpu_wr;
    assign bus1.cpu_din  = bus0.cpu_din;

    boot_prog_ram #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    boot_prog_ram #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] prog [14] = '{16'h0004, 16'h0007, 16'h0015, 16'h0040, 16'h00C1,
                               16'h0244, 16'h06CB, 16'h1461, 16'h3D24, 16'hB76C,
                               16'h2645, 16'h72D0, 16'h5871, 16'h0855};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd0(input string tag, input int addr, input logic [15:0] exp);
        bus0.cpu_addr = 7'(addr);
        #1;
        chk(tag, 32'(bus0.cpu_dout), 32'(exp));
    endtask

    task automatic send(input logic [15:0] data, input logic last);
        bus0.ld_valid = 1'b1;
        bus0.ld_data  = data;
        bus0.ld_last  = last;
        tick();
        bus0.ld_valid = 1'b0;
        bus0.ld_last  = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        bus0.ld_start = 1'b0;
        bus0.ld_valid = 1'b0;
        bus0.ld_data  = 16'h0000;
        bus0.ld_last  = 1'b0;
        bus0.cpu_addr = 7'd0;
        bus0.cpu_wr   = 1'b0;
        bus0.cpu_din  = 16'h0000;
        tick();
        tick();
        chk("rst_hold",  32'(bus0.cpu_hold), 32'd1);
        chk("rst_ready", 32'(bus0.ld_ready), 32'd0);
        chk("rst_count", 32'(bus0.ld_count), 32'd0);
        chk("rst_ovf",   32'(bus0.ld_ovf),   32'd0);
        chk("rst_dout1", 32'(bus1.cpu_dout), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_hold", 32'(bus0.cpu_hold), 32'd1);

        // 14-word load with gaps after words 3 and 7
        bus0.ld_start = 1'b1;
        tick();
        bus0.ld_start = 1'b0;
        chk("load_ready", 32'(bus0.ld_ready), 32'd1);
        chk("load_hold",  32'(bus0.cpu_hold), 32'd1);
        for (int i = 0; i < 14; i++) begin
            if (i == 3 || i == 7) begin
                bus0.ld_data = 16'hDEAD;
                tick();
            end
            send(prog[i], (i == 13));
        end
        chk("p14_count", 32'(bus0.ld_count), 32'd14);
        chk("p14_hold",  32'(bus0.cpu_hold), 32'd0);
        chk("p14_ready", 32'(bus0.ld_ready), 32'd0);
        chk("p14_ovf",   32'(bus0.ld_ovf),   32'd0);
        bus0.ld_valid = 1'b1;
        bus0.ld_data  = 16'hBAD0;
        tick();
        bus0.ld_valid = 1'b0;
        chk("run_valid_ignored", 32'(bus0.ld_count), 32'd14);
        for (int i = 0; i < 14; i++) begin
            rd0($sformatf("p14_ram%0d", i), i, prog[i]);
        end

        // CPU write/read in RUN
        @(negedge clk);
        bus0.cpu_addr = 7'd5;
        bus0.cpu_wr   = 1'b1;
        bus0.cpu_din  = 16'h1234;
        #1;
        chk("wr_before_edge0", 32'(bus0.cpu_dout), 32'(prog[5]));
        tick();
        bus0.cpu_wr = 1'b0;
        chk("wr_after_edge0", 32'(bus0.cpu_dout), 32'h1234);
        chk("rdw_old1",       32'(bus1.cpu_dout), 32'(prog[5]));
        tick();
        chk("rd_next1",       32'(bus1.cpu_dout), 32'h1234);

        // Overflow: 128 words, no ld_last
        bus0.ld_start = 1'b1;
        tick();
        bus0.ld_start = 1'b0;
        for (int i = 0; i < 128; i++) begin
            send(16'(i) ^ 16'hA500, 1'b0);
            if (i == 126) begin
                chk("ovf_pre_hold", 32'(bus0.cpu_hold), 32'd1);
            end
        end
        chk("ovf_flag",  32'(bus0.ld_ovf),   32'd1);
        chk("ovf_count", 32'(bus0.ld_count), 32'd128);
        chk("ovf_hold",  32'(bus0.cpu_hold), 32'd0);
        send(16'hBEEF, 1'b0);
        chk("ovf_w129_count", 32'(bus0.ld_count), 32'd128);
        rd0("ovf_ram0",   0,   16'hA500);
        rd0("ovf_ram5",   5,   16'hA505);
        rd0("ovf_ram127", 127, 16'hA57F);

        // ld_start in RUN together with a CPU write
        @(negedge clk);
        bus0.cpu_addr = 7'd10;
        bus0.cpu_wr   = 1'b1;
        bus0.cpu_din  = 16'h5A5A;
        bus0.ld_start = 1'b1;
        tick();
        bus0.cpu_wr   = 1'b0;
        bus0.ld_start = 1'b0;
        chk("rl_hold",  32'(bus0.cpu_hold), 32'd1);
        chk("rl_ready", 32'(bus0.ld_ready), 32'd1);
        chk("rl_count", 32'(bus0.ld_count), 32'd0);
        chk("rl_ovf",   32'(bus0.ld_ovf),   32'd0);
        send(16'h9999, 1'b0);
        chk("rl_count1", 32'(bus0.ld_count), 32'd1);
        // Restart in LOAD beats the simultaneous word
        bus0.ld_start = 1'b1;
        send(16'h7777, 1'b0);
        bus0.ld_start = 1'b0;
        chk("restart_count", 32'(bus0.ld_count), 32'd0);
        bus0.cpu_addr = 7'd20;
        bus0.cpu_wr   = 1'b1;
        bus0.cpu_din  = 16'hFFFF;
        send(16'h1111, 1'b0);
        bus0.cpu_wr   = 1'b0;
        send(16'h2222, 1'b0);
        send(16'h3333, 1'b1);
        chk("rl_done_count", 32'(bus0.ld_count), 32'd3);
        chk("rl_done_hold",  32'(bus0.cpu_hold), 32'd0);
        rd0("rl_ram0",  0,  16'h1111);
        rd0("rl_ram1",  1,  16'h2222);
        rd0("rl_ram2",  2,  16'h3333);
        rd0("rl_ram3",  3,  16'hA503);
        rd0("rl_ram10", 10, 16'h5A5A);
        rd0("rl_ram20", 20, 16'hA514);

        // Reset in the middle of a load keeps the words already written
        @(negedge clk);
        bus0.ld_start = 1'b1;
        tick();
        bus0.ld_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(16'hC000 + 16'(i), 1'b0);
        end
        chk("mid_count6", 32'(bus0.ld_count), 32'd6);
        reset = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus0.ld_count), 32'd0);
        chk("mid_rst_hold",  32'(bus0.cpu_hold), 32'd1);
        chk("mid_rst_ready", 32'(bus0.ld_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd0($sformatf("mid_ram%0d", i), i, 16'hC000 + 16'(i));
        end
        rd0("mid_ram6", 6, 16'hA506);
        reset = 1'b1;
        tick();
        chk("post_rst_hold", 32'(bus0.cpu_hold), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
